// File: rtl/reg_file_wb_if.sv
// Bus interface for reg_file_wb: write request plus two combinational read ports.
// The master drives writes and read addresses; the slave (register file) returns data and busy.
interface reg_file_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] indata;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wb_busy;

    modport master (
        output wr_en, wr_addr, indata, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_busy
    );

    modport slave (
        input  wr_en, wr_addr, indata, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_busy
    );
endinterface

// File: rtl/reg_file_wb.sv
// 32x32 register file with a one-cycle write-back register and read bypass from it.
// Optional macro REG_FILE_WB_R0_ZERO_EN hardwires register 0 to zero.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_wb_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    logic              commit_en;
    logic              bypass_a, bypass_b;
    logic [DATA_W-1:0] rd_a, rd_b;

    always_comb begin
        wb_valid_d = bus.wr_en;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (bus.wr_en) begin
            wb_addr_d = bus.wr_addr;
            wb_data_d = bus.indata;
        end
`ifdef REG_FILE_WB_R0_ZERO_EN
        commit_en = wb_valid_q && (wb_addr_q != '0);
`else
        commit_en = wb_valid_q;
`endif
    end

    // Capture and commit share an edge; commit always uses the previously held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            if (commit_en) begin
                regs_q[wb_addr_q] <= wb_data_q;
            end
        end
    end

    always_comb begin
        bypass_a = wb_valid_q && (bus.rd_addr_a == wb_addr_q);
        bypass_b = wb_valid_q && (bus.rd_addr_b == wb_addr_q);
`ifdef REG_FILE_WB_R0_ZERO_EN
        if (wb_addr_q == '0) begin
            bypass_a = 1'b0;
            bypass_b = 1'b0;
        end
`endif
        rd_a = bypass_a ? wb_data_q : regs_q[bus.rd_addr_a];
        rd_b = bypass_b ? wb_data_q : regs_q[bus.rd_addr_b];
`ifdef REG_FILE_WB_R0_ZERO_EN
        if (bus.rd_addr_a == '0) rd_a = '0;
        if (bus.rd_addr_b == '0) rd_b = '0;
`endif
    end

    assign bus.rd_data_a = rd_a;
    assign bus.rd_data_b = rd_b;
    assign bus.wb_busy   = wb_valid_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed testbench for reg_file_wb: expectations queued with each stimulus step,
// then drained and compared against the read ports and wb_busy.
module tb_reg_file_wb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam int SEL_A    = 0;
    localparam int SEL_B    = 1;
    localparam int SEL_BUSY = 2;

    typedef struct {
        string             tag;
        int                sel;
        logic [DATA_W-1:0] exp;
    } expect_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    expect_t sbQueue[$];

    reg_file_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] waddr,
                                 input logic [DATA_W-1:0] wdata,
                                 input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        bus.wr_en     = we;
        bus.wr_addr   = waddr;
        bus.indata    = wdata;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
    endtask

    task automatic expectPush(input string tag, input int sel, input logic [DATA_W-1:0] exp);
        expect_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sbQueue.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        expect_t           e;
        logic [DATA_W-1:0] obs;
        #1;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            case (e.sel)
                SEL_A:   obs = bus.rd_data_a;
                SEL_B:   obs = bus.rd_data_b;
                default: obs = {{(DATA_W-1){1'b0}}, bus.wb_busy};
            endcase
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    logic [DATA_W-1:0] r0Expect;

    initial begin
        checks   = 0;
        failures = 0;
`ifdef REG_FILE_WB_R0_ZERO_EN
        r0Expect = '0;
`else
        r0Expect = 32'hFFFF_FFFF;
`endif
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        expectPush("reset_rd_a", SEL_A, 32'h0);
        expectPush("reset_rd_b", SEL_B, 32'h0);
        expectPush("reset_busy", SEL_BUSY, 32'h0);
        checkOutput();
        #3 rst_n = 1'b1;
        tick();

        // Write latency: invisible before edge N, bypassed after N, from array after N+1.
        applyStimulus(1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd3);
        expectPush("lat_before_edge", SEL_A, 32'h0);
        checkOutput();
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        expectPush("lat_bypass", SEL_A, 32'h1234_5678);
        expectPush("lat_busy", SEL_BUSY, 32'h1);
        checkOutput();
        tick();
        expectPush("lat_array", SEL_A, 32'h1234_5678);
        expectPush("lat_busy_clear", SEL_BUSY, 32'h0);
        checkOutput();

        // Back-to-back writes to r7: later value wins.
        applyStimulus(1'b1, 5'd7, 32'h1, 5'd0, 5'd7);
        expectPush("b2b_before", SEL_B, 32'h0);
        checkOutput();
        tick();
        applyStimulus(1'b1, 5'd7, 32'h2, 5'd0, 5'd7);
        expectPush("b2b_first", SEL_B, 32'h1);
        expectPush("b2b_busy", SEL_BUSY, 32'h1);
        checkOutput();
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
        expectPush("b2b_second", SEL_B, 32'h2);
        checkOutput();
        tick();
        expectPush("b2b_settled", SEL_B, 32'h2);
        expectPush("b2b_busy_clear", SEL_BUSY, 32'h0);
        checkOutput();

        // Dual port: r1 and r2, then swap, then both on r1.
        applyStimulus(1'b1, 5'd1, 32'hAAAA_0000, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd2, 32'h0000_BBBB, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        tick();
        expectPush("dual_a_r1", SEL_A, 32'hAAAA_0000);
        expectPush("dual_b_r2", SEL_B, 32'h0000_BBBB);
        checkOutput();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd2, 5'd1);
        expectPush("swap_a_r2", SEL_A, 32'h0000_BBBB);
        expectPush("swap_b_r1", SEL_B, 32'hAAAA_0000);
        checkOutput();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
        expectPush("same_a_r1", SEL_A, 32'hAAAA_0000);
        expectPush("same_b_r1", SEL_B, 32'hAAAA_0000);
        checkOutput();

        // Bypass vs array: pending r4 update must not disturb r9 on the other port.
        applyStimulus(1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h11, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd9);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h22, 5'd4, 5'd9);
        expectPush("byp_old_r4", SEL_A, 32'h11);
        checkOutput();
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd9);
        expectPush("byp_new_r4", SEL_A, 32'h22);
        expectPush("byp_r9_array", SEL_B, 32'h99);
        checkOutput();
        tick();
        expectPush("byp_r4_commit", SEL_A, 32'h22);
        checkOutput();

        // Register 0 behaviour depends on the build option.
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        expectPush("r0_before", SEL_A, 32'h0);
        checkOutput();
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        expectPush("r0_pending", SEL_A, r0Expect);
        expectPush("r0_busy", SEL_BUSY, 32'h1);
        checkOutput();
        tick();
        expectPush("r0_after", SEL_A, r0Expect);
        expectPush("r0_busy_clear", SEL_BUSY, 32'h0);
        checkOutput();

        // Async reset mid-cycle clears array and discards the pending r6 write.
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        tick();
        expectPush("rst_pre_r5", SEL_A, 32'hDEAD_BEEF);
        checkOutput();
        applyStimulus(1'b1, 5'd6, 32'h66, 5'd5, 5'd6);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        expectPush("rst_pre_r6_bypass", SEL_B, 32'h66);
        expectPush("rst_pre_busy", SEL_BUSY, 32'h1);
        checkOutput();
        #2 rst_n = 1'b0;
        expectPush("rst_mid_r5", SEL_A, 32'h0);
        expectPush("rst_mid_r6", SEL_B, 32'h0);
        expectPush("rst_mid_busy", SEL_BUSY, 32'h0);
        checkOutput();
        rst_n = 1'b1;
        tick();
        expectPush("rst_post_r6", SEL_B, 32'h0);
        expectPush("rst_post_r5", SEL_A, 32'h0);
        expectPush("rst_post_busy", SEL_BUSY, 32'h0);
        checkOutput();
        tick();
        expectPush("rst_post2_r6", SEL_B, 32'h0);
        checkOutput();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
